// File: rtl/alu_4bit.sv
// Registered 4-bit ALU: eight operations, result and carry/borrow captured on enabled clock edges.
// Optional ALU_FLAGS_EN adds registered Zero and signed Overflow outputs.
module alu_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             Carry_Out
`ifdef ALU_FLAGS_EN
    ,
    output logic             Zero,
    output logic             Overflow
`endif
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH:0]   wide_sum;
    logic [WIDTH:0]   wide_diff;
    logic [WIDTH-1:0] result;
    logic             carry;

    // The extra top bit of the widened difference is the unsigned borrow (A < B).
    assign wide_sum  = {1'b0, A} + {1'b0, B};
    assign wide_diff = {1'b0, A} - {1'b0, B};

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (ALU_Sel)
            OP_ADD: begin
                result = wide_sum[WIDTH-1:0];
                carry  = wide_sum[WIDTH];
            end
            OP_SUB: begin
                result = wide_diff[WIDTH-1:0];
                carry  = wide_diff[WIDTH];
            end
            OP_AND: result = A & B;
            OP_OR:  result = A | B;
            OP_XOR: result = A ^ B;
            OP_NOT: result = ~A;
            OP_SHL: begin
                result = {A[WIDTH-2:0], 1'b0};
                carry  = A[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, A[WIDTH-1:1]};
                carry  = A[0];
            end
            default: begin
                result = '0;
                carry  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ALU_Out   <= '0;
            Carry_Out <= 1'b0;
        end else if (en) begin
            ALU_Out   <= result;
            Carry_Out <= carry;
        end
    end

`ifdef ALU_FLAGS_EN
    logic overflow;

    // Signed overflow: the result sign disagrees with what the operand signs allow.
    always_comb begin
        overflow = 1'b0;
        case (ALU_Sel)
            OP_ADD:  overflow = (A[WIDTH-1] == B[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
            OP_SUB:  overflow = (A[WIDTH-1] != B[WIDTH-1]) && (result[WIDTH-1] != A[WIDTH-1]);
            default: overflow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Zero     <= 1'b0;
            Overflow <= 1'b0;
        end else if (en) begin
            Zero     <= (result == '0);
            Overflow <= overflow;
        end
    end
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Self-checking bench for alu_4bit: directed steps plus randomized traffic against an integer reference model.
// Flag outputs are checked only when ALU_FLAGS_EN is defined.
module tb_alu_4bit;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] ALU_Sel;
    logic [3:0] ALU_Out;
    logic       Carry_Out;
`ifdef ALU_FLAGS_EN
    logic       Zero;
    logic       Overflow;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_out;
    logic       exp_carry;
    logic       exp_zero;
    logic       exp_ov;

    alu_4bit #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .A         (A),
        .B         (B),
        .ALU_Sel   (ALU_Sel),
        .ALU_Out   (ALU_Out),
        .Carry_Out (Carry_Out)
`ifdef ALU_FLAGS_EN
        ,
        .Zero      (Zero),
        .Overflow  (Overflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model works on plain integers and signed ranges, not bit slices.
    function automatic void refModel(input int a, input int b, input int sel,
                                     output logic [3:0] o, output logic c,
                                     output logic z, output logic v);
        int r;
        int sa;
        int sb;
        int sr;
        sa = (a >= 8) ? a - 16 : a;
        sb = (b >= 8) ? b - 16 : b;
        r  = 0;
        c  = 1'b0;
        v  = 1'b0;
        case (sel)
            0: begin r = (a + b) % 16; c = (a + b) > 15; sr = sa + sb; v = (sr > 7) || (sr < -8); end
            1: begin r = (a - b + 16) % 16; c = a < b; sr = sa - sb; v = (sr > 7) || (sr < -8); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 15 - a;
            6: begin r = (a * 2) % 16; c = a >= 8; end
            default: begin r = a / 2; c = (a % 2) == 1; end
        endcase
        o = 4'(r);
        z = (r == 0);
    endfunction

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [2:0] sel, input logic e);
        @(negedge clk);
        A = a;
        B = b;
        ALU_Sel = sel;
        en = e;
        @(posedge clk);
        #1;
        if (e && rst_n)
            refModel(int'(a), int'(b), int'(sel), exp_out, exp_carry, exp_zero, exp_ov);
    endtask

    task automatic checkOutput(input string tag, input logic [3:0] o, input logic c);
        checks++;
        assert (ALU_Out === o) else begin
            failures++;
            $error("[TB] FAIL %s out: got %b expected %b", tag, ALU_Out, o);
        end
        checks++;
        assert (Carry_Out === c) else begin
            failures++;
            $error("[TB] FAIL %s carry: got %b expected %b", tag, Carry_Out, c);
        end
    endtask

    task automatic checkFlags(input string tag, input logic z, input logic v);
`ifdef ALU_FLAGS_EN
        checks++;
        assert (Zero === z) else begin
            failures++;
            $error("[TB] FAIL %s zero: got %b expected %b", tag, Zero, z);
        end
        checks++;
        assert (Overflow === v) else begin
            failures++;
            $error("[TB] FAIL %s overflow: got %b expected %b", tag, Overflow, v);
        end
`else
        if (tag.len() < 0) $display("[TB] %s %b %b", tag, z, v);
`endif
    endtask

    task automatic checkModel(input string tag);
        checkOutput(tag, exp_out, exp_carry);
        checkFlags(tag, exp_zero, exp_ov);
    endtask

    logic [3:0] sweep_out [8];
    logic       sweep_c   [8];

    initial begin
        sweep_out = '{4'b0100, 4'b0010, 4'b0001, 4'b0011, 4'b0010, 4'b1100, 4'b0110, 4'b0001};
        sweep_c   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_out = '0; exp_carry = 1'b0; exp_zero = 1'b0; exp_ov = 1'b0;

        rst_n = 1'b0; en = 1'b0; A = '0; B = '0; ALU_Sel = '0;
        #1;
        checkOutput("reset", 4'b0000, 1'b0);
        checkFlags("reset", 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 8; s++) begin
            applyStimulus(4'b0011, 4'b0001, 3'(s), 1'b1);
            checkOutput($sformatf("sweep%0d", s), sweep_out[s], sweep_c[s]);
            checkModel($sformatf("sweep_model%0d", s));
        end

        applyStimulus(4'b1111, 4'b0001, 3'b000, 1'b1);
        checkOutput("add_wrap", 4'b0000, 1'b1);
        checkFlags("add_wrap", 1'b1, 1'b0);
        applyStimulus(4'b0001, 4'b0010, 3'b001, 1'b1);
        checkOutput("sub_wrap", 4'b1111, 1'b1);
        checkFlags("sub_wrap", 1'b0, 1'b0);

        applyStimulus(4'b0111, 4'b0001, 3'b000, 1'b1);
        checkOutput("add_ovf", 4'b1000, 1'b0);
        checkFlags("add_ovf", 1'b0, 1'b1);
        applyStimulus(4'b1000, 4'b0001, 3'b001, 1'b1);
        checkOutput("sub_ovf", 4'b0111, 1'b0);
        checkFlags("sub_ovf", 1'b0, 1'b1);

        applyStimulus(4'b0011, 4'b0001, 3'b000, 1'b1);
        checkOutput("hold_load", 4'b0100, 1'b0);
        for (int h = 0; h < 3; h++) begin
            applyStimulus(4'(h + 9), 4'(h + 7), 3'(h + 5), 1'b0);
            checkOutput($sformatf("hold%0d", h), 4'b0100, 1'b0);
        end

        applyStimulus(4'b0011, 4'b0001, 3'b101, 1'b1);
        checkOutput("pre_reset", 4'b1100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 4'b0000, 1'b0);
        checkFlags("async_reset", 1'b0, 1'b0);
        en = 1'b1;
        A = 4'b1001; B = 4'b0101; ALU_Sel = 3'b000;
        @(posedge clk);
        #1;
        checkOutput("reset_held", 4'b0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(4'b0010, 4'b0011, 3'b000, 1'b1);
        checkOutput("after_reset", 4'b0101, 1'b0);

        applyStimulus(4'b0100, 4'b0100, 3'b000, 1'b1);
        A = 4'b0001; B = 4'b0001; ALU_Sel = 3'b000;
        #3;
        checkOutput("latency_hold", 4'b1000, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("latency_load", 4'b0010, 1'b0);
        refModel(1, 1, 0, exp_out, exp_carry, exp_zero, exp_ov);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                          3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            checkModel($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
